// File: rtl/mc_ctrl_if.sv
// Bus between the multi-cycle controller and the datapath/memories.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req;
   logic             dmem_req;
   logic             dm_we;
   logic             ir_wr;
   logic             pc_wr;
   logic [1:0]       npc_sel;
   logic             rf_wr;
   logic [1:0]       a3_sel;
   logic [1:0]       wd_sel;
   logic             alu_b_sel;
   logic [1:0]       ext_op;
   logic [1:0]       alu_op;
   logic [2:0]       state;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, funct, zero, imem_ready, dmem_ready,
      output imem_req, dmem_req, dm_we, ir_wr, pc_wr, npc_sel, rf_wr,
             a3_sel, wd_sel, alu_b_sel, ext_op, alu_op, state, illegal, retired
   );

   modport slave (
      output opcode, funct, zero, imem_ready, dmem_ready,
      input  imem_req, dmem_req, dm_we, ir_wr, pc_wr, npc_sel, rf_wr,
             a3_sel, wd_sel, alu_b_sel, ext_op, alu_op, state, illegal, retired
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXE/MEM/WB sequencing with
// wait-state aware memory handshakes, a sticky illegal flag and a retire counter.
module mc_ctrl #(
   parameter int CNT_W  = 32,
   parameter int RA_REG = 31
) (
   input logic        clk,
   input logic        reset,
   mc_ctrl_if.master  bus
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXE    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [1:0] A3_RA = (RA_REG == 31) ? 2'd2 : 2'd2;

   state_t           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;

   logic is_r, op_addu, op_subu, op_jr, op_nop;
   logic op_ori, op_lui, op_lw, op_sw, op_beq, op_jal, legal;

   logic       imem_req_c, dmem_req_c, dm_we_c, ir_wr_c, pc_wr_c, rf_wr_c;
   logic [1:0] npc_sel_c, a3_sel_c, wd_sel_c, ext_op_c, alu_op_c;
   logic       alu_b_sel_c;

   always_comb begin
      is_r    = (bus.opcode == 6'h00);
      op_addu = is_r && (bus.funct == 6'h21);
      op_subu = is_r && (bus.funct == 6'h23);
      op_jr   = is_r && (bus.funct == 6'h08);
      op_nop  = is_r && (bus.funct == 6'h00);
      op_ori  = (bus.opcode == 6'h0D);
      op_lui  = (bus.opcode == 6'h0F);
      op_lw   = (bus.opcode == 6'h23);
      op_sw   = (bus.opcode == 6'h2B);
      op_beq  = (bus.opcode == 6'h04);
      op_jal  = (bus.opcode == 6'h03);
      legal   = op_addu | op_subu | op_jr | op_nop | op_ori | op_lui |
                op_lw | op_sw | op_beq | op_jal;
   end

   always_comb begin
      state_d     = state_q;
      illegal_d   = illegal_q;
      retire      = 1'b0;
      imem_req_c  = 1'b0;
      dmem_req_c  = 1'b0;
      dm_we_c     = 1'b0;
      ir_wr_c     = 1'b0;
      pc_wr_c     = 1'b0;
      rf_wr_c     = 1'b0;
      npc_sel_c   = 2'd0;
      a3_sel_c    = 2'd0;
      wd_sel_c    = 2'd0;
      alu_b_sel_c = 1'b0;
      ext_op_c    = 2'd0;
      alu_op_c    = 2'd0;
      case (state_q)
         FETCH: begin
            imem_req_c = 1'b1;
            if (bus.imem_ready) begin
               ir_wr_c = 1'b1;
               pc_wr_c = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (!legal) begin
               illegal_d = 1'b1;
               state_d   = FETCH;
            end else if (op_jal) begin
               // PC already holds PC+4 here, so the link value comes straight from PC
               rf_wr_c   = 1'b1;
               a3_sel_c  = A3_RA;
               wd_sel_c  = 2'd2;
               pc_wr_c   = 1'b1;
               npc_sel_c = 2'd2;
               retire    = 1'b1;
               state_d   = FETCH;
            end else if (op_jr) begin
               pc_wr_c   = 1'b1;
               npc_sel_c = 2'd3;
               retire    = 1'b1;
               state_d   = FETCH;
            end else if (op_nop) begin
               retire  = 1'b1;
               state_d = FETCH;
            end else begin
               state_d = EXE;
            end
         end
         EXE: begin
            if (op_lw || op_sw) begin
               alu_b_sel_c = 1'b1;
               ext_op_c    = 2'd1;
               state_d     = MEM;
            end else if (op_beq) begin
               alu_op_c  = 2'd1;
               pc_wr_c   = bus.zero;
               npc_sel_c = 2'd1;
               retire    = 1'b1;
               state_d   = FETCH;
            end else if (op_subu) begin
               alu_op_c = 2'd1;
               state_d  = WB;
            end else if (op_ori) begin
               alu_b_sel_c = 1'b1;
               alu_op_c    = 2'd2;
               state_d     = WB;
            end else if (op_lui) begin
               alu_b_sel_c = 1'b1;
               ext_op_c    = 2'd2;
               alu_op_c    = 2'd3;
               state_d     = WB;
            end else if (op_addu) begin
               state_d = WB;
            end else begin
               state_d = FETCH;
            end
         end
         MEM: begin
            // ALU controls stay at the address computation while the access waits
            alu_b_sel_c = 1'b1;
            ext_op_c    = 2'd1;
            dmem_req_c  = 1'b1;
            dm_we_c     = op_sw;
            if (bus.dmem_ready) begin
               if (op_sw) begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end
         end
         WB: begin
            rf_wr_c  = 1'b1;
            a3_sel_c = is_r ? 2'd1 : 2'd0;
            wd_sel_c = op_lw ? 2'd1 : 2'd0;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         default: state_d = FETCH;
      endcase
      retired_d = retired_q + CNT_W'(retire);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // Strobes are held off for the whole time reset is low, not just after the edge
   assign bus.imem_req  = imem_req_c & reset;
   assign bus.dmem_req  = dmem_req_c & reset;
   assign bus.dm_we     = dm_we_c & reset;
   assign bus.ir_wr     = ir_wr_c & reset;
   assign bus.pc_wr     = pc_wr_c & reset;
   assign bus.rf_wr     = rf_wr_c & reset;
   assign bus.npc_sel   = npc_sel_c;
   assign bus.a3_sel    = a3_sel_c;
   assign bus.wd_sel    = wd_sel_c;
   assign bus.alu_b_sel = alu_b_sel_c;
   assign bus.ext_op    = ext_op_c;
   assign bus.alu_op    = alu_op_c;
   assign bus.state     = state_q;
   assign bus.illegal   = illegal_q;
   assign bus.retired   = retired_q;
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle main controller for the MIPS core. It sequences one instruction through FETCH/DECODE/EXE/MEM/WB using the opcode/funct fields split out of the instruction register. It drives all datapath write strobes and mux selects, and handshakes with instruction and data memories that may insert wait states. It also keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter
RA_REG, 31, link register index (informational; datapath uses a3_sel=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
opcode  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU zero flag
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dm_we  out  1  data memory write (qualifies dmem_req)
ir_wr  out  1  load IR
pc_wr  out  1  load PC
npc_sel  out  2  0 PC+4, 1 branch, 2 jump26, 3 rs
rf_wr  out  1  register file write
a3_sel  out  2  0 rt, 1 rd, 2 RA
wd_sel  out  2  0 ALU, 1 DM, 2 PC
alu_b_sel  out  1  0 rt, 1 extended imm
ext_op  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
alu_op  out  2  0 add, 1 sub, 2 or, 3 pass B
state  out  3  current state encoding
illegal  out  1  sticky unsupported-opcode flag
retired  out  CNT_W  count of completed instructions

Behaviour:
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Registered state; all other outputs except illegal/retired are combinational from state, opcode, funct, zero and ready inputs.
- Reset (reset==0 at a clk edge): state<=FETCH, illegal<=0, retired<=0. While reset is low, every strobe (imem_req, dmem_req, dm_we, ir_wr, pc_wr, rf_wr) is forced to 0. Reset mid-instruction abandons it with no writes.
- Supported: addu (0/100001), subu (0/100011), jr (0/001000), nop (0/000000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, jal 000011.
- FETCH: imem_req=1. If imem_ready is high: ir_wr=1, pc_wr=1, npc_sel=0, next state DECODE. Otherwise stay and assert no writes. Wait length is unbounded.
- DECODE: no memory request.
  - jal: rf_wr=1, a3_sel=2, wd_sel=2 (PC already holds PC+4), pc_wr=1, npc_sel=2. Retire; go to FETCH.
  - jr: pc_wr=1, npc_sel=3. Retire; go to FETCH.
  - nop: retire; go to FETCH.
  - Unsupported opcode or funct: illegal<=1 (sticky until reset). No writes, no retire; go to FETCH.
  - All others: go to EXE.
- EXE:
  - addu: alu_b_sel=0, alu_op=0; go to WB.
  - subu: alu_b_sel=0, alu_op=1; go to WB.
  - ori: alu_b_sel=1, ext_op=0, alu_op=2; go to WB.
  - lui: alu_b_sel=1, ext_op=2, alu_op=3; go to WB.
  - lw/sw: alu_b_sel=1, ext_op=1, alu_op=0; go to MEM.
  - beq: alu_b_sel=0, alu_op=1. pc_wr=zero, npc_sel=1. Retire; go to FETCH.
- MEM: hold the EXE ALU controls (address stays registered in the datapath ALUOut). dmem_req=1, dm_we=1 for sw only. If dmem_ready is low, stay. If dmem_ready is high: sw retires and goes to FETCH; lw goes to WB.
- WB: rf_wr=1.
  - R-type: a3_sel=1, wd_sel=0.
  - ori/lui: a3_sel=0, wd_sel=0.
  - lw: a3_sel=0, wd_sel=1.
  - Retire; go to FETCH.
- Retire: retired<=retired+1 on the cycle the instruction leaves for FETCH. Wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0.
- Minimum cycle counts with zero-wait memory:
  - jal/jr/nop: 2 cycles.
  - beq: 3 cycles.
  - sw: 4 cycles.
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
  - Each extra wait cycle adds 1.

Test Plan:
- Reset held low 3 cycles with imem_ready=1 -> all strobes 0, state=0, retired=0. After release, the first cycle shows imem_req=1, ir_wr=1, pc_wr=1.
- addu (opcode 0, funct 100001), zero-wait -> states 0,1,2,4,0. In WB: rf_wr=1, a3_sel=1, wd_sel=0. retired increments by 1.
- lw with dmem_ready low 2 cycles -> MEM lasts 3 cycles with dmem_req=1 and dm_we=0; WB has wd_sel=1, a3_sel=0. Total 7 cycles. sw with the same waits -> dm_we=1 throughout MEM, no WB.
- beq with zero=1 -> EXE pc_wr=1, npc_sel=1. With zero=0 -> pc_wr=0. Both return to FETCH and retire.
- jal -> DECODE rf_wr=1, a3_sel=2, wd_sel=2, pc_wr=1, npc_sel=2, then FETCH. jr -> npc_sel=3, rf_wr=0.
- opcode 111111 -> illegal=1 stays set across later valid instructions, retired unchanged, no writes. Reset clears it. Counter preloaded via force to all-ones wraps to 0.
